// File: rtl/lbist_pkg.sv
// lbist_pkg: shared types and constants for the LBIST loop.
//   state_e        : output response analyzer session state.
//   POLY4/8/16     : default feedback tap masks, also used by the pattern
//                    generator so both ends agree on the polynomial.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0]  POLY4  = 4'b1001;
  localparam logic [7:0]  POLY8  = 8'b1011_1000;
  localparam logic [15:0] POLY16 = 16'b1101_0000_0000_1000;

endpackage

// File: rtl/misr_core.sv
// misr_core: multiple-input signature register.
//   clk, rst     : clock, synchronous active-high reset (loads SEED)
//   load         : reload SEED on this edge (session start)
//   en           : compact din on this edge
//   din          : response word
//   sig          : current register contents
//   sig_next     : value the register takes if load is low this edge
module misr_core #(
  parameter int              BITS = 4,
  parameter logic [BITS-1:0] POLY = 4'b1001,
  parameter logic [BITS-1:0] SEED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] sig,
  output logic [BITS-1:0] sig_next
);

  logic [BITS-1:0] sig_q;
  logic            fb;

  assign fb       = ^(POLY & sig_q);
  assign sig_next = en ? ({fb, sig_q[BITS-1:1]} ^ din) : sig_q;
  assign sig      = sig_q;

  always_ff @(posedge clk) begin
    if (rst || load) sig_q <= SEED;
    else             sig_q <= sig_next;
  end

endmodule

// File: rtl/lbist_ora.sv
// lbist_ora: LBIST output response analyzer.
// Compacts CUT responses into a MISR during a session started by start_i
// and compares the final signature with golden on the end_in pulse.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a session (taken in IDLE or DONE)
//   resp/resp_valid : CUT response word and its qualifier
//   end_in          : last-pattern pulse; golden sampled on this cycle
//   signature       : MISR contents
//   busy/done/pass  : session status, pass valid while done
//   pat_count       : saturating count of compacted words
//   cnt_ovf         : sticky, set by an increment attempted at all-ones
module lbist_ora
  import lbist_pkg::*;
#(
  parameter int              BITS  = 4,
  parameter logic [BITS-1:0] POLY  = POLY4,
  parameter logic [BITS-1:0] SEED  = '0,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BITS-1:0]  resp,
  input  logic             resp_valid,
  input  logic             end_in,
  input  logic [BITS-1:0]  golden,
  output logic [BITS-1:0]  signature,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pat_count,
  output logic             cnt_ovf
);

  state_e           state_q;
  logic             busy_q, done_q, pass_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BITS-1:0]  sig_next;
  logic             take_start, compact;

  // start is only honoured outside RUN; it wins over end_in in IDLE/DONE
  // simply because end_in has no effect there.
  assign take_start = start && (state_q != RUN);
  assign compact    = resp_valid && (state_q == RUN);

  misr_core #(.BITS(BITS), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (take_start),
    .en       (compact),
    .din      (resp),
    .sig      (signature),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (compact) begin
            if (&cnt_q) ovf_q <= 1'b1;
            else        cnt_q <= cnt_q + CNT_W'(1);
          end
          if (end_in) begin
            // sig_next already folds in this cycle's word (or holds).
            pass_q  <= (sig_next == golden);
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin // IDLE, DONE
          if (take_start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign pat_count = cnt_q;
  assign cnt_ovf   = ovf_q;

endmodule

// File: tb/tb_lbist_ora.sv
// Scoreboard bench for lbist_ora: the driver pushes the reference model's
// expected outputs for every cycle; a monitor pops and compares after each edge.
module tb_lbist_ora;
  localparam int         BITS  = 4;
  localparam logic [3:0] POLY  = 4'b1001;
  localparam logic [3:0] SEED  = 4'h0;
  localparam int         CNT_W = 2;

  logic clk = 0, rst = 0, start = 0, resp_valid = 0, end_in = 0;
  logic [BITS-1:0]  resp = 0, golden = 0, signature;
  logic             busy, done, pass, cnt_ovf;
  logic [CNT_W-1:0] pat_count;

  int checks = 0, errors = 0;

  lbist_ora #(.BITS(BITS), .POLY(POLY), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .resp(resp), .resp_valid(resp_valid),
    .end_in(end_in), .golden(golden), .signature(signature), .busy(busy),
    .done(done), .pass(pass), .pat_count(pat_count), .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sig; int busy; int done; int pass; int cnt; int ovf;
  } exp_t;
  exp_t sb[$];

  // Reference model: session mode 0=idle 1=run 2=done.
  int m_mode = 0, m_sig = 0, m_pass = 0, m_cnt = 0, m_ovf = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  function automatic int mstep(int s, int r);
    int fb;
    fb = $countones(s & int'(POLY)) % 2;
    return ((s >> 1) + fb * (1 << (BITS - 1))) ^ r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, push expectation, then
  // return 2 time units after the edge with outputs settled.
  task automatic cyc(input logic r, input logic st, input logic rv,
                     input int rs, input logic e, input int g);
    int nsig;
    rst = r; start = st; resp_valid = rv; resp = rs[BITS-1:0];
    end_in = e; golden = g[BITS-1:0];
    if (r) begin
      m_mode = 0; m_sig = SEED; m_pass = 0; m_cnt = 0; m_ovf = 0;
    end else if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_sig = SEED; m_pass = 0; m_cnt = 0; m_ovf = 0;
      end
    end else begin
      nsig = rv ? mstep(m_sig, rs) : m_sig;
      if (rv) begin
        if (m_cnt == CMAX) m_ovf = 1;
        else m_cnt++;
      end
      if (e) begin
        m_pass = (nsig == (g & ((1 << BITS) - 1)));
        m_mode = 2;
      end
      m_sig = nsig;
    end
    sb.push_back('{m_sig, m_mode == 1, m_mode == 2, m_pass, m_cnt, m_ovf});
    @(posedge clk); #2;
  endtask

  task automatic idle1(); cyc(0, 0, 0, 0, 0, 0); endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("sb_signature", int'(signature), x.sig);
        chk("sb_busy",      int'(busy),      x.busy);
        chk("sb_done",      int'(done),      x.done);
        chk("sb_pass",      int'(pass),      x.pass);
        chk("sb_pat_count", int'(pat_count), x.cnt);
        chk("sb_cnt_ovf",   int'(cnt_ovf),   x.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, rs, g;
    logic st, rv, e, r;
    @(posedge clk); #2;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    chk("rst_sig", signature, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);     chk("rst_pass", pass, 0);
    chk("rst_cnt", pat_count, 0); chk("rst_ovf", cnt_ovf, 0);

    // Session compaction: 1,2,3 -> 1, A, E, golden E
    cyc(0, 1, 0, 0, 0, 0);  chk("s1_busy", busy, 1);
    cyc(0, 0, 1, 1, 0, 0);  chk("s1_sig1", signature, 4'h1);
    cyc(0, 0, 1, 2, 0, 0);  chk("s1_sigA", signature, 4'hA);
    cyc(0, 0, 1, 3, 1, 14); chk("s1_sigE", signature, 4'hE);
    chk("s1_pass", pass, 1); chk("s1_cnt", pat_count, 3); chk("s1_done", done, 1);
    idle1(); chk("s1_hold_sig", signature, 4'hE); chk("s1_hold_pass", pass, 1);

    // Back-to-back from DONE, then gaps and golden mismatch (D)
    cyc(0, 1, 0, 0, 0, 0);
    chk("b2b_busy", busy, 1); chk("b2b_sig", signature, 0);
    chk("b2b_pass", pass, 0); chk("b2b_done", done, 0);
    cyc(0, 0, 1, 1, 0, 0); idle1();
    cyc(0, 0, 1, 2, 0, 0); idle1(); idle1();
    cyc(0, 0, 1, 3, 1, 13);
    chk("mm_sig", signature, 4'hE); chk("mm_pass", pass, 0); chk("mm_done", done, 1);

    // Empty session, golden 0
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 5, 1, 0);
    chk("empty_pass", pass, 1); chk("empty_cnt", pat_count, 0); chk("empty_done", done, 1);

    // start+end_in together in IDLE: start wins
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 1, 0);
    chk("se_busy", busy, 1); chk("se_done", done, 0); chk("se_sig", signature, 0);

    // Counter saturation: 5 valid words with CNT_W=2
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, i + 4, 0, 0);
    chk("sat_cnt", pat_count, 3); chk("sat_ovf", cnt_ovf, 1);
    chk("sat_sig", signature, m_sig);
    cyc(0, 0, 0, 0, 1, 0);

    // Reset mid-session, then ignored end_in / resp_valid
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 9, 0, 0); cyc(0, 0, 1, 6, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("abort_busy", busy, 0); chk("abort_sig", signature, 0);
    cyc(0, 0, 1, 3, 1, 0);
    chk("ign_done", done, 0); chk("ign_sig", signature, 0); chk("ign_cnt", pat_count, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) == 0);
      rv = ($urandom_range(0, 9) < 6);
      e  = ($urandom_range(0, 11) == 0);
      rs = $urandom_range(0, (1 << BITS) - 1);
      p  = (m_mode == 1 && rv) ? mstep(m_sig, rs) : m_sig;
      g  = $urandom_range(0, 1) ? p : $urandom_range(0, (1 << BITS) - 1);
      cyc(r, st, rv, rs, e, g);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lbist_ora.md
# lbist_ora

Output response analyzer for the LBIST loop: compacts the circuit-under-test response word into an N-bit multiple-input signature register (MISR) during a BIST session. At the end-of-pattern-cycle pulse from the random pattern generator, it compares the final signature against a golden value. Sits downstream of the CUT, clocked with the pattern generator; the BIST controller issues `start` and reads `done`/`pass`.

## Interface
- `BITS`, 4: MISR width, equal to the CUT response width; ≥ 2.
- `POLY`, 4'b1001: feedback tap mask; bit i set means `sig[i]` feeds the XOR.
- `SEED`, 0: MISR value loaded at session start.
- `CNT_W`, 16: width of the compacted-pattern counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a session; sampled only in IDLE or DONE.
- `resp` in BITS: CUT response word.
- `resp_valid` in 1: `resp` is compacted this cycle.
- `end_in` in 1: single-cycle pulse marking the last pattern of the session.
- `golden` in BITS: expected signature; sampled on the `end_in` cycle.
- `signature` out BITS: current MISR contents.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done` is high.
- `pat_count` out CNT_W: number of compacted words, saturating.
- `cnt_ovf` out 1: sticky; set when `pat_count` saturates.

## Operation
- MISR update when `resp_valid` is high in RUN:
  - `fb = ^(POLY & sig)`
  - `sig_next = {fb, sig[BITS-1:1]} ^ resp`
  - Otherwise `sig` holds.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `start` → RUN.
  - The same edge sets `sig` to SEED, `pat_count` to 0, `cnt_ovf` to 0 and `pass` to 0.
- RUN:
  - Compacts each valid word; `pat_count` increments per compacted word and saturates at all-ones.
  - An increment attempted at all-ones sets `cnt_ovf`.
  - `start` is ignored.
- RUN with `end_in`:
  - The word on the same cycle is included if valid.
  - `pass` is set to (`sig_next` == `golden`), where `sig_next` is `sig` itself when `resp_valid` is low.
  - FSM → DONE.
- DONE:
  - `signature`, `pass`, `pat_count` and `cnt_ovf` hold.
  - `start` → RUN with a fresh seed load, as from IDLE; there is no return to IDLE except via `rst`.
- `end_in` in IDLE or DONE is ignored. `resp_valid` outside RUN is ignored.

## Timing
- Reset values: state IDLE, `signature` = SEED, `busy` 0, `done` 0, `pass` 0, `pat_count` 0, `cnt_ovf` 0.
- `rst` mid-session aborts to IDLE on the next edge; partial signature is discarded.
- `rst` has priority over `start` and `end_in`.
- All outputs are registered.
- Compaction latency: `signature` reflects a word one cycle after its `resp_valid` edge.
- `busy` rises on the cycle after `start` is sampled.
- `done`/`pass` rise on the cycle after the `end_in` edge.
- `start` and `end_in` on the same cycle in IDLE: `start` is taken and `end_in` is ignored.
- `end_in` on the first RUN cycle with no valid words: `pass` = (SEED == `golden`), `pat_count` = 0.
- Back-to-back sessions: `start` in DONE gives `busy` on the next cycle with no IDLE bubble.

## Structure
- Package `lbist_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - default 4/8/16-bit POLY constants, shared with the pattern generator.
- Sub-module `misr_core`:
  - parameters BITS, POLY, SEED.
  - ports `clk`, `rst`, `load`, `en`, `din`.
  - outputs `sig` and combinational `sig_next`.
  - holds only the register and next-state XOR.
- `lbist_ora` holds the FSM, counter, compare and flags.

## Test plan
- Session compaction: BITS=4, POLY=1001, SEED=0; `start`, then `resp` 1, 2, 3 valid on consecutive cycles, with `end_in` on the third and `golden`=E → `signature` steps 1, A, E; `pass`=1, `pat_count`=3, `done`=1.
- Golden mismatch: same stimulus, `golden`=D → `pass`=0, `signature`=E.
- Validity gaps and empty session: `resp_valid` low on cycles between 1, 2, 3 → same final E; a session with `end_in` and no valid words and `golden`=0 → `pass`=1, `pat_count`=0.
- Counter saturation: CNT_W=2; 5 valid words → `pat_count`=3, `cnt_ovf`=1, signature still equals the reference model.
- Reset and ignored inputs: `rst` after 2 words in RUN → IDLE next cycle, `signature`=0, `busy`=0; a following `end_in` is ignored and `done` stays 0.
- Back-to-back sessions: `start` while in DONE → RUN on the next cycle, `signature` reloaded to SEED, `pass` cleared, then a new session compacts correctly.
